// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers host payload bytes, then emits
// header {len,addr}, len payload bytes and a parity byte, stalling on busy.
module router_pkt_tx #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned CW       = 7,
  parameter logic [7:0]  PAR_FLIP = 8'h01
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          buf_full,
  output logic [CW-1:0] buf_count,
  output logic          wr_ovf,
  input  logic          start,
  input  logic [1:0]    addr,
  input  logic [5:0]    len,
  input  logic          corrupt,
  input  logic          busy,
  output logic          pkt_valid,
  output logic [7:0]    data_out,
  output logic          tx_active,
  output logic          done,
  output logic          start_err
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;
  state_t state, state_n;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [5:0]    len_q, sent, sent_n;
  logic          corrupt_q;
  logic [7:0]    parity, parity_n, data_n;
  logic          pkt_valid_n, tx_active_n, done_n, start_err_n;
  logic          accept, push, pop;
  logic [CW-1:0] count_n;

  assign push = wr_en && !buf_full;

  always_comb begin
    state_n     = state;
    data_n      = data_out;
    pkt_valid_n = pkt_valid;
    tx_active_n = tx_active;
    done_n      = 1'b0;
    start_err_n = 1'b0;
    parity_n    = parity;
    sent_n      = sent;
    accept      = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0 && addr != 2'd3 && buf_count >= CW'(len)) begin
            accept      = 1'b1;
            state_n     = HEADER;
            data_n      = {len, addr};
            parity_n    = {len, addr};
            pkt_valid_n = 1'b1;
            tx_active_n = 1'b1;
            sent_n      = '0;
          end else begin
            start_err_n = 1'b1;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          pop      = 1'b1;
          data_n   = mem[rd_ptr];
          parity_n = parity ^ mem[rd_ptr];
          sent_n   = 6'd1;
          state_n  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          // parity already includes the byte currently on data_out
          if (sent == len_q) begin
            state_n     = PARITY;
            data_n      = parity ^ (corrupt_q ? PAR_FLIP : 8'h00);
            pkt_valid_n = 1'b0;
          end else begin
            pop      = 1'b1;
            data_n   = mem[rd_ptr];
            parity_n = parity ^ mem[rd_ptr];
            sent_n   = sent + 6'd1;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          state_n     = IDLE;
          done_n      = 1'b1;
          tx_active_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_n = buf_count;
    if (push && !pop)      count_n = buf_count + CW'(1);
    else if (pop && !push) count_n = buf_count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      buf_full  <= 1'b0;
      wr_ovf    <= 1'b0;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      parity    <= 8'h00;
      sent      <= '0;
      len_q     <= '0;
      corrupt_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      buf_count <= count_n;
      buf_full  <= (count_n == CW'(DEPTH));
      wr_ovf    <= wr_en && buf_full;
      data_out  <= data_n;
      pkt_valid <= pkt_valid_n;
      tx_active <= tx_active_n;
      done      <= done_n;
      start_err <= start_err_n;
      parity    <= parity_n;
      sent      <= sent_n;
      if (accept) begin
        len_q     <= len;
        corrupt_q <= corrupt;
      end
    end
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected bytes are queued when a packet is
// started and compared as each byte is accepted (tx_active with busy low).
module tb_router_pkt_tx;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       buf_full;
  logic [6:0] buf_count;
  logic       wr_ovf;
  logic       start = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [5:0] len = 6'd0;
  logic       corrupt = 1'b0;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       start_err;

  int n_checks = 0;
  int n_fail   = 0;
  int hold_cnt = 0;

  logic [8:0] exp_q[$];
  logic [7:0] model_buf[$];

  router_pkt_tx #(.DEPTH(64), .CW(7), .PAR_FLIP(8'h01)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .buf_full(buf_full), .buf_count(buf_count), .wr_ovf(wr_ovf),
    .start(start), .addr(addr), .len(len), .corrupt(corrupt), .busy(busy),
    .pkt_valid(pkt_valid), .data_out(data_out), .tx_active(tx_active),
    .done(done), .start_err(start_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && tx_active && !busy) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got pv=%0b data=%02h, expected none", pkt_valid, data_out);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({pkt_valid, data_out} !== e) begin
          n_fail++;
          $display("FAIL stream_byte: got pv=%0b data=%02h, expected pv=%0b data=%02h",
                   pkt_valid, data_out, e[8], e[7:0]);
        end
      end
    end
    if (!reset && pkt_valid && data_out == 8'h02) hold_cnt++;
  end

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(posedge clock); #1;
    wr_en = 1'b0;
    if (model_buf.size() < 64) model_buf.push_back(b);
  endtask

  task automatic send_packet(input logic [1:0] a, input logic [5:0] l, input logic c, input bit stall);
    logic [7:0] hdr, p, b;
    bit stalled, seen;
    hdr = {l, a};
    p = hdr;
    exp_q.push_back({1'b1, hdr});
    for (int i = 0; i < l; i++) begin
      b = model_buf.pop_front();
      p ^= b;
      exp_q.push_back({1'b1, b});
    end
    exp_q.push_back({1'b0, c ? (p ^ 8'h01) : p});
    start = 1'b1; addr = a; len = l; corrupt = c;
    @(posedge clock); #1;
    start = 1'b0;
    n_checks++;
    if (pkt_valid !== 1'b1 || data_out !== hdr) begin
      n_fail++;
      $display("FAIL header_latency: got pv=%0b data=%02h, expected pv=1 data=%02h", pkt_valid, data_out, hdr);
    end
    stalled = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (stall && !stalled && pkt_valid && data_out == 8'h02) begin
        busy = 1'b1;
        repeat (3) @(posedge clock);
        #1 busy = 1'b0;
        stalled = 1;
      end
      @(posedge clock); #1;
      if (done) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: got no done pulse, expected done within 400 cycles");
    end
    n_checks++;
    if (exp_q.size() != 0 || tx_active !== 1'b0 || buf_count !== 7'(model_buf.size())) begin
      n_fail++;
      $display("FAIL packet_end: got left=%0d tx_active=%0b count=%0d, expected left=0 tx_active=0 count=%0d",
               exp_q.size(), tx_active, buf_count, model_buf.size());
    end
  endtask

  task automatic reject(input logic [1:0] a, input logic [5:0] l);
    start = 1'b1; addr = a; len = l; corrupt = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    n_checks++;
    if (start_err !== 1'b1 || pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_pulse: got start_err=%0b pv=%0b, expected start_err=1 pv=0", start_err, pkt_valid);
    end
    @(posedge clock); #1;
    n_checks++;
    if (start_err !== 1'b0 || pkt_valid !== 1'b0 || tx_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_after: got start_err=%0b pv=%0b tx=%0b, expected 0 0 0", start_err, pkt_valid, tx_active);
    end
  endtask

  task automatic push_seq5();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({pkt_valid, data_out, tx_active, done, start_err, wr_ovf, buf_full, buf_count} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_values: got pv=%0b data=%02h tx=%0b done=%0b serr=%0b ovf=%0b full=%0b cnt=%0d, expected all 0",
               pkt_valid, data_out, tx_active, done, start_err, wr_ovf, buf_full, buf_count);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_good_packet();  push_seq5(); send_packet(2'd2, 6'd5, 1'b0, 0); endtask
  task automatic test_bad_parity();   push_seq5(); send_packet(2'd2, 6'd5, 1'b1, 0); endtask

  task automatic test_stall();
    push_seq5();
    hold_cnt = 0;
    send_packet(2'd2, 6'd5, 1'b0, 1);
    n_checks++;
    if (hold_cnt != 4) begin
      n_fail++;
      $display("FAIL stall_hold: got byte 02 shown %0d cycles, expected 4", hold_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    send_packet(2'd0, 6'd3, 1'b0, 0);
    send_packet(2'd1, 6'd2, 1'b0, 0);
  endtask

  task automatic test_rejects();
    push_byte(8'hA5); push_byte(8'h5A);
    reject(2'd1, 6'd0);
    reject(2'd3, 6'd1);
    reject(2'd1, 6'd5);
  endtask

  task automatic test_reset_mid_payload();
    bit seen;
    @(posedge clock); #1 reset = 1'b1;
    #2;
    exp_q.delete(); model_buf.delete();
    @(posedge clock); #1 reset = 1'b0;
    push_seq5();
    exp_q.push_back({1'b1, 8'h16}); exp_q.push_back({1'b1, 8'h01}); exp_q.push_back({1'b1, 8'h02});
    start = 1'b1; addr = 2'd2; len = 6'd5; corrupt = 1'b0;
    @(posedge clock); #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (pkt_valid && data_out == 8'h02) begin seen = 1; break; end
      @(posedge clock); #1;
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (!seen || pkt_valid !== 1'b0 || buf_count !== 7'd0 || tx_active !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got seen=%0b pv=%0b cnt=%0d tx=%0b, expected 1 0 0 0", seen, pkt_valid, buf_count, tx_active);
    end
    exp_q.delete(); model_buf.delete();
    @(posedge clock); #1 reset = 1'b0;
    push_seq5();
    send_packet(2'd2, 6'd5, 1'b0, 0);
  endtask

  task automatic test_buffer_full();
    for (int i = 0; i < 64; i++) push_byte(8'($urandom));
    n_checks++;
    if (buf_full !== 1'b1 || buf_count !== 7'd64) begin
      n_fail++;
      $display("FAIL buf_full: got full=%0b cnt=%0d, expected full=1 cnt=64", buf_full, buf_count);
    end
    push_byte(8'hEE);
    n_checks++;
    if (wr_ovf !== 1'b1 || buf_count !== 7'd64) begin
      n_fail++;
      $display("FAIL wr_ovf: got ovf=%0b cnt=%0d, expected ovf=1 cnt=64", wr_ovf, buf_count);
    end
    @(posedge clock); #1;
    n_checks++;
    if (wr_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ovf_pulse: got ovf=%0b, expected 0", wr_ovf);
    end
    send_packet(2'd1, 6'd63, 1'b0, 0);
    n_checks++;
    if (buf_count !== 7'd1 || buf_full !== 1'b0) begin
      n_fail++;
      $display("FAIL max_len_count: got cnt=%0d full=%0b, expected cnt=1 full=0", buf_count, buf_full);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_stall();
    test_back_to_back();
    test_rejects();
    test_reset_mid_payload();
    test_buffer_full();
    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
